// File: rtl/if_pc_stage_if.sv
// Fetch-stage bundle: downstream control in, imem address/data, IF/ID register and halt status out.
interface if_pc_stage_if #(
  parameter int ADDR_W  = 7,
  parameter int INSTR_W = 16
);
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_base;
  logic [ADDR_W-1:0]  redirect_offset;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  ifid_pc_plus1;
  logic               ifid_valid;
  logic               halted;

  modport slave (
    input  stall, redirect_valid, redirect_base, redirect_offset, imem_rdata,
    output imem_addr, ifid_instr, ifid_pc_plus1, ifid_valid, halted
  );

  modport master (
    output stall, redirect_valid, redirect_base, redirect_offset, imem_rdata,
    input  imem_addr, ifid_instr, ifid_pc_plus1, ifid_valid, halted
  );
endinterface

// File: rtl/if_pc_stage.sv
// Instruction-fetch stage: owns the PC, drives imem address, fills the IF/ID register.
module if_pc_stage #(
  parameter int                  ADDR_W      = 7,
  parameter int                  INSTR_W     = 16,
  parameter logic [INSTR_W-1:0]  NOP_INSTR   = 16'h0000,
  parameter logic [3:0]          HALT_OPCODE = 4'hF
) (
  input  logic          clk,
  input  logic          rst_n,
  if_pc_stage_if.slave  bus
);
  typedef enum logic {FETCH, HALT} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pcp1_q, pcp1_d;
  logic               vld_q, vld_d;

  logic [ADDR_W-1:0]  pc_plus1;
  logic [ADDR_W-1:0]  target;
  logic               is_hlt;

  // Modular adds: carry-out intentionally dropped by the ADDR_W-wide result.
  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign target   = bus.redirect_base + bus.redirect_offset;
  assign is_hlt   = (bus.imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      pcp1_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp1_q  <= pcp1_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp1_d  = pcp1_q;
    vld_d   = vld_q;
    if (bus.redirect_valid) begin
      // Redirect beats stall and halt; the in-flight fetch becomes a bubble.
      pc_d    = target;
      instr_d = NOP_INSTR;
      pcp1_d  = '0;
      vld_d   = 1'b0;
      state_d = FETCH;
    end else if (bus.stall) begin
      // Hold everything, including a HLT that is re-fetched once the stall drops.
    end else if (state_q == HALT) begin
      instr_d = NOP_INSTR;
      pcp1_d  = '0;
      vld_d   = 1'b0;
    end else begin
      instr_d = bus.imem_rdata;
      pcp1_d  = pc_plus1;
      vld_d   = 1'b1;
      if (is_hlt) state_d = HALT;
      else        pc_d    = pc_plus1;
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.ifid_instr    = instr_q;
  assign bus.ifid_pc_plus1 = pcp1_q;
  assign bus.ifid_valid    = vld_q;
  assign bus.halted        = (state_q == HALT);
endmodule
